// File: rtl/clock_pkg.sv
// Shared mode encodings and default timing parameters for the clock-setting controller.
package clock_pkg;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_SET_H = 2'b01;
    localparam logic [1:0] MODE_SET_M = 2'b10;

    localparam int DEB_CYCLES_DEF   = 20;
    localparam int REPEAT_DELAY_DEF = 4;
    localparam int TIMEOUT_S_DEF    = 15;

    // Mode-key sequence; the unused 11 encoding falls back to RUN.
    function automatic logic [1:0] next_mode(input logic [1:0] m);
        case (m)
            MODE_RUN:   return MODE_SET_H;
            MODE_SET_H: return MODE_SET_M;
            default:    return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key: 2-FF synchroniser, consecutive-sample debounce and press-edge pulse.
module key_debounce
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic CP,
    input  logic nCR,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          raw_pressed;

    assign raw_pressed = ~sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], key_n};
        level_d = level_q;
        cnt_d   = '0;
        // the count only runs while the synchronised level disagrees with the debounced one
        if (raw_pressed != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = raw_pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            sync_q  <= 2'b11;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock run/set controller: counter enables, hour/minute adjust with auto-repeat, idle timeout, blink.
//   state      | meaning
//   MODE_RUN   | time runs from Tick1Hz, adjust key ignored
//   MODE_SET_H | time frozen, adjust key steps hours, hour digits blink
//   MODE_SET_M | time frozen, adjust key steps minutes, minute digits blink; leaving clears seconds
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int TIMEOUT_S    = TIMEOUT_S_DEF
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       KeyMode_n,
    input  logic       KeyAdj_n,
    input  logic       Tick1Hz,
    input  logic       Tick4Hz,
    input  logic       SecCarry,
    input  logic       MinCarry,
    output logic       EnSec,
    output logic       EnMin,
    output logic       EnHour,
    output logic       ClrSec,
    output logic [1:0] Mode,
    output logic       BlinkH,
    output logic       BlinkM
);

    localparam int HW = $clog2(REPEAT_DELAY + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam logic [HW-1:0] HOLD_FULL = HW'(REPEAT_DELAY);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_S - 1);

    logic          mode_lvl, mode_press;
    logic          adj_lvl, adj_press;

    logic [1:0]    mode_q, mode_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] to_q, to_d;
    logic          phase_q, phase_d;
    logic          en_sec_q, en_sec_d;
    logic          en_min_q, en_min_d;
    logic          en_hour_q, en_hour_d;
    logic          clr_sec_q, clr_sec_d;

    logic          in_set, adj_ev, rpt, timeout, adj_pulse;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_mode (
        .CP    (CP),
        .nCR   (nCR),
        .key_n (KeyMode_n),
        .level (mode_lvl),
        .press (mode_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_adj (
        .CP    (CP),
        .nCR   (nCR),
        .key_n (KeyAdj_n),
        .level (adj_lvl),
        .press (adj_press)
    );

    always_comb begin
        in_set = (mode_q != MODE_RUN);
        adj_ev = adj_press & ~mode_press;

        hold_d = hold_q;
        rpt    = 1'b0;
        if (!adj_lvl || mode_press || !in_set) begin
            hold_d = '0;
        end else if (Tick4Hz) begin
            if (hold_q == HOLD_FULL) begin
                rpt = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end

        // a held key counts as activity, so a long auto-repeat never times out underneath the user
        to_d    = to_q;
        timeout = 1'b0;
        if (!in_set || mode_lvl || adj_lvl) begin
            to_d = '0;
        end else if (Tick1Hz) begin
            if (to_q == TO_LAST) begin
                timeout = 1'b1;
                to_d    = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end

        mode_d = mode_q;
        if (mode_press) begin
            mode_d = next_mode(mode_q);
        end else if (timeout) begin
            mode_d = MODE_RUN;
        end

        adj_pulse = in_set & (adj_ev | rpt);
        en_sec_d  = ~in_set & Tick1Hz;
        if (in_set) begin
            en_min_d  = (mode_q == MODE_SET_M) & adj_pulse;
            en_hour_d = (mode_q == MODE_SET_H) & adj_pulse;
        end else begin
            en_min_d  = Tick1Hz & SecCarry;
            en_hour_d = Tick1Hz & SecCarry & MinCarry;
        end
        clr_sec_d = (mode_q == MODE_SET_M) & (mode_d == MODE_RUN);

        if (mode_d != mode_q) begin
            phase_d = 1'b0;
        end else begin
            phase_d = phase_q ^ Tick4Hz;
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            mode_q    <= MODE_RUN;
            hold_q    <= '0;
            to_q      <= '0;
            phase_q   <= 1'b0;
            en_sec_q  <= 1'b0;
            en_min_q  <= 1'b0;
            en_hour_q <= 1'b0;
            clr_sec_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            hold_q    <= hold_d;
            to_q      <= to_d;
            phase_q   <= phase_d;
            en_sec_q  <= en_sec_d;
            en_min_q  <= en_min_d;
            en_hour_q <= en_hour_d;
            clr_sec_q <= clr_sec_d;
        end
    end

    assign EnSec  = en_sec_q;
    assign EnMin  = en_min_q;
    assign EnHour = en_hour_q;
    assign ClrSec = clr_sec_q;
    assign Mode   = mode_q;
    assign BlinkH = (mode_q == MODE_SET_H) & phase_q;
    assign BlinkM = (mode_q == MODE_SET_M) & phase_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: stimulus queues expected enable pulses, a monitor pops them.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       KeyMode_n = 1'b1;
    logic       KeyAdj_n = 1'b1;
    logic       Tick1Hz = 1'b0;
    logic       Tick4Hz = 1'b0;
    logic       SecCarry = 1'b0;
    logic       MinCarry = 1'b0;
    logic       EnSec, EnMin, EnHour, ClrSec, BlinkH, BlinkM;
    logic [1:0] Mode;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [3:0] exp_q[$];   // {EnSec, EnMin, EnHour, ClrSec}
    logic [3:0] mon_exp;

    clock_set_ctrl dut (
        .CP        (CP),
        .nCR       (nCR),
        .KeyMode_n (KeyMode_n),
        .KeyAdj_n  (KeyAdj_n),
        .Tick1Hz   (Tick1Hz),
        .Tick4Hz   (Tick4Hz),
        .SecCarry  (SecCarry),
        .MinCarry  (MinCarry),
        .EnSec     (EnSec),
        .EnMin     (EnMin),
        .EnHour    (EnHour),
        .ClrSec    (ClrSec),
        .Mode      (Mode),
        .BlinkH    (BlinkH),
        .BlinkM    (BlinkM)
    );

    always #5 CP = ~CP;

    function automatic logic [7:0] outs();
        return {EnSec, EnMin, EnHour, ClrSec, Mode, BlinkH, BlinkM};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b, expected %b", name, act, req);
    endtask

    always @(negedge CP) begin
        if (nCR && (EnSec | EnMin | EnHour | ClrSec)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: got %b, expected no pulse", {EnSec, EnMin, EnHour, ClrSec});
            end else begin
                mon_exp = exp_q.pop_front();
                check("pulse", {4'b0, EnSec, EnMin, EnHour, ClrSec}, {4'b0, mon_exp});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CP);
    endtask

    task automatic tick(input logic t1, input logic t4);
        Tick1Hz = t1;
        Tick4Hz = t4;
        @(negedge CP);
        Tick1Hz = 1'b0;
        Tick4Hz = 1'b0;
    endtask

    task automatic press_mode();
        KeyMode_n = 1'b0;
        cyc(30);
        KeyMode_n = 1'b1;
        cyc(30);
    endtask

    task automatic press_adj();
        KeyAdj_n = 1'b0;
        cyc(30);
        KeyAdj_n = 1'b1;
        cyc(30);
    endtask

    initial begin
        cyc(3);
        check("reset_state", outs(), 8'h00);
        nCR = 1'b1;
        cyc(3);

        // RUN enables from Tick1Hz and carries
        exp_q.push_back(4'b1000); tick(1'b1, 1'b1);
        SecCarry = 1'b1;
        exp_q.push_back(4'b1100); tick(1'b1, 1'b0);
        MinCarry = 1'b1;
        exp_q.push_back(4'b1110); tick(1'b1, 1'b1);
        cyc(1);
        check("run_carry_one_cycle", outs(), 8'h00);
        tick(1'b0, 1'b1);
        SecCarry = 1'b0;
        exp_q.push_back(4'b1000); tick(1'b1, 1'b0);
        MinCarry = 1'b0;
        cyc(2);

        press_adj();
        check("run_adj_ignored", outs(), 8'h00);

        KeyMode_n = 1'b0; cyc(10); KeyMode_n = 1'b1; cyc(30);
        check("short_bounce_no_change", outs(), 8'h00);

        for (int i = 0; i < 5; i++) begin
            KeyMode_n = i[0];
            cyc(1);
        end
        KeyMode_n = 1'b0; cyc(30); KeyMode_n = 1'b1; cyc(30);
        check("bounce_then_set_h", outs(), {4'b0, MODE_SET_H, 2'b00});
        tick(1'b0, 1'b1);
        check("blink_h_on", outs(), {4'b0, MODE_SET_H, 2'b10});
        tick(1'b0, 1'b1);
        check("blink_h_off", outs(), {4'b0, MODE_SET_H, 2'b00});

        // hold adjust for 12 Tick4Hz: one press pulse, then repeats on ticks 5..12
        exp_q.push_back(4'b0010);
        KeyAdj_n = 1'b0;
        cyc(30);
        for (int k = 1; k <= 12; k++) begin
            if (k >= 5) exp_q.push_back(4'b0010);
            tick(k % 4 == 0, 1'b1);
            cyc(3);
        end
        KeyAdj_n = 1'b1;
        cyc(30);
        check("repeat_all_seen", 8'(exp_q.size()), 8'd0);
        check("repeat_done_set_h", outs(), {4'b0, MODE_SET_H, 2'b00});

        KeyMode_n = 1'b0; KeyAdj_n = 1'b0; cyc(30);
        KeyMode_n = 1'b1; KeyAdj_n = 1'b1; cyc(30);
        check("mode_wins_over_adj", outs(), {4'b0, MODE_SET_M, 2'b00});

        exp_q.push_back(4'b0100);
        press_adj();
        check("set_m_adj_seen", 8'(exp_q.size()), 8'd0);

        for (int k = 1; k <= 14; k++) begin
            tick(1'b1, 1'b1);
            cyc(2);
        end
        check("set_m_before_timeout", outs(), {4'b0, MODE_SET_M, 2'b00});
        exp_q.push_back(4'b0001);
        tick(1'b1, 1'b1);
        cyc(2);
        check("timeout_to_run", outs(), 8'h00);
        exp_q.push_back(4'b1000);
        tick(1'b1, 1'b0);
        cyc(1);

        press_mode();
        check("set_h_again", outs(), {4'b0, MODE_SET_H, 2'b00});
        for (int k = 1; k <= 15; k++) begin
            tick(1'b1, 1'b0);
            cyc(2);
        end
        check("set_h_timeout_run", outs(), 8'h00);

        press_mode();
        press_mode();
        check("set_m_by_keys", outs(), {4'b0, MODE_SET_M, 2'b00});
        exp_q.push_back(4'b0001);
        press_mode();
        check("key_exit_run", outs(), 8'h00);

        // reset in the middle of a SET_M auto-repeat
        press_mode();
        press_mode();
        exp_q.push_back(4'b0100);
        KeyAdj_n = 1'b0;
        cyc(30);
        for (int k = 1; k <= 6; k++) begin
            if (k >= 5) exp_q.push_back(4'b0100);
            tick(1'b0, 1'b1);
            if (k < 6) cyc(3);
        end
        check("pre_reset_enmin", outs(), {4'b0100, MODE_SET_M, 2'b00});
        #1 nCR = 1'b0;
        #1 check("async_reset_outputs", outs(), 8'h00);
        cyc(3);
        nCR = 1'b1;
        cyc(40);
        KeyAdj_n = 1'b1;
        cyc(40);
        check("after_reset_run", outs(), 8'h00);
        check("queue_empty", 8'(exp_q.size()), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
